// File: rtl/tw_pkg.sv
// Shared types and constants for the tw_vgg front end: scheduler state
// encoding, error bit positions and the default frame geometry.
package tw_pkg;

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} sched_state_t;

    localparam int ERR_LEN  = 0;
    localparam int ERR_SPUR = 1;

    // The classifier consumes 2**LOG2_IMG_SIZE samples per image; the dense
    // tail needs two frame times to drain, hence the doubled start period.
    localparam int TW_LOG2_IMG_SIZE = 10;
    localparam int TW_FRAME_LEN     = 1 << TW_LOG2_IMG_SIZE;
    localparam int TW_MIN_PERIOD    = 2 * TW_FRAME_LEN;

    // Bits needed to hold max_val, never less than 1.
    function automatic int cnt_w(input int max_val);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((max_val >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sat_down_cntr.sv
// Loadable down-counter that sticks at zero; a load wins over the decrement.
module sat_down_cntr
    import tw_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tw_frame_sched.sv
// Frame admission controller for tw_vgg: paces frame starts, limits frames
// in flight, tags pipeline results in order and records framing errors.
module tw_frame_sched
    import tw_pkg::*;
#(
    parameter int FRAME_LEN    = TW_FRAME_LEN,
    parameter int MIN_PERIOD   = TW_MIN_PERIOD,
    parameter int MAX_INFLIGHT = 4,
    parameter int TAG_W        = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_vld,
    output logic                              s_rdy,
    input  logic [31:0]                       s_data,
    input  logic                              s_last,
    output logic                              p_vld,
    output logic [31:0]                       p_data,
    input  logic                              p_res_vld,
    output logic                              o_vld,
    output logic [TAG_W-1:0]                  o_tag,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic [1:0]                        err
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int PER_W = cnt_w(MIN_PERIOD - 1);
    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [PER_W-1:0] PER_LOAD = PER_W'(MIN_PERIOD - 1);
    localparam logic [INF_W-1:0] INF_MAX  = INF_W'(MAX_INFLIGHT);

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [INF_W-1:0] inflight_q, inflight_d;
    logic [TAG_W-1:0] res_id_q, res_id_d;
    logic [TAG_W-1:0] o_tag_q, o_tag_d;
    logic             o_vld_q, o_vld_d;
    logic             p_vld_q, p_vld_d;
    logic [31:0]      p_data_q, p_data_d;
    logic [1:0]       err_q, err_d;
    logic [PER_W-1:0] per_cnt;

    logic can_start;
    logic rdy;
    logic accept;
    logic frame_start;
    logic is_last;
    logic res_ok;

    sat_down_cntr #(
        .W (PER_W)
    ) u_per_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (frame_start),
        .load_val (PER_LOAD),
        .cnt      (per_cnt)
    );

    always_comb begin
        can_start   = (per_cnt == '0) && (inflight_q < INF_MAX);
        rdy         = (state_q == STREAM) || can_start;
        accept      = s_vld && rdy;
        frame_start = accept && (state_q == IDLE);
        is_last     = (idx_q == LAST_IDX);
        // Spurious results are judged against the credit held before this cycle.
        res_ok      = p_res_vld && (inflight_q != '0);

        state_d    = state_q;
        idx_d      = idx_q;
        inflight_d = inflight_q;
        res_id_d   = res_id_q;
        o_tag_d    = o_tag_q;
        o_vld_d    = res_ok;
        p_vld_d    = accept;
        p_data_d   = p_data_q;
        err_d      = err_q;

        if (state_q == IDLE) begin
            if (accept) begin
                idx_d   = IDX_W'(1);
                state_d = STREAM;
            end
        end else begin
            if (accept) begin
                if (is_last) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end

        if (accept) begin
            p_data_d = s_data;
            // s_last is only audited; framing follows idx alone.
            if (s_last != is_last) err_d[ERR_LEN] = 1'b1;
        end

        if (res_ok) begin
            o_tag_d  = res_id_q;
            res_id_d = res_id_q + 1'b1;
        end else if (p_res_vld) begin
            err_d[ERR_SPUR] = 1'b1;
        end

        if (frame_start && !res_ok) begin
            inflight_d = inflight_q + 1'b1;
        end else if (res_ok && !frame_start) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            inflight_q <= '0;
            res_id_q   <= '0;
            o_tag_q    <= '0;
            o_vld_q    <= 1'b0;
            p_vld_q    <= 1'b0;
            p_data_q   <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            inflight_q <= inflight_d;
            res_id_q   <= res_id_d;
            o_tag_q    <= o_tag_d;
            o_vld_q    <= o_vld_d;
            p_vld_q    <= p_vld_d;
            p_data_q   <= p_data_d;
            err_q      <= err_d;
        end
    end

    assign s_rdy    = rdy;
    assign p_vld    = p_vld_q;
    assign p_data   = p_data_q;
    assign o_vld    = o_vld_q;
    assign o_tag    = o_tag_q;
    assign inflight = inflight_q;
    assign err      = err_q;

endmodule

// File: doc/tw_frame_sched.md
# tw_frame_sched

Frame admission controller in front of the `tw_vgg` classifier pipeline. It accepts I/Q samples over a valid/ready handshake and forwards whole frames to the pipeline's `vld_in`/`data_in`. A new frame starts only when two conditions hold: the minimum frame-start period has elapsed, so the serialised dense tail is never overrun, and the number of in-flight frames is below a limit. It also matches each pipeline result pulse to a frame tag and flags framing errors.

## Interface
- `FRAME_LEN`, 1024: samples per frame; power of 2, ≥ 2.
- `MIN_PERIOD`, 2048: minimum cycles between consecutive frame starts; ≥ 1.
- `MAX_INFLIGHT`, 4: maximum frames started but not yet answered; ≥ 1.
- `TAG_W`, 8: result tag width.

- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `s_vld`  in  1  upstream sample valid.
- `s_rdy`  out  1  upstream ready; combinational from state and counters.
- `s_data`  in  32  sample, {Q[15:0], I[15:0]}.
- `s_last`  in  1  upstream end-of-frame marker; checked only, not used for framing.
- `p_vld`  out  1  to pipeline `vld_in`.
- `p_data`  out  32  to pipeline `data_in`.
- `p_res_vld`  in  1  pipeline `vld_out`; one pulse per frame, results in order.
- `o_vld`  out  1  result-tag valid.
- `o_tag`  out  TAG_W  tag of the result pulse.
- `inflight`  out  $clog2(MAX_INFLIGHT+1)  frames outstanding.
- `err`  out  2  sticky errors: bit0 = length mismatch, bit1 = spurious result.

## Operation
- **States.** FSM with two states: IDLE and STREAM.
  - `can_start = (per_cnt == 0) & (inflight < MAX_INFLIGHT)`.
  - `s_rdy = (state == STREAM) | (state == IDLE & can_start)`.
  - Acceptance means `s_vld & s_rdy`.
- **IDLE.** Acceptance is a frame start:
  - `idx <= 1`; state goes to STREAM.
  - `per_cnt <= MIN_PERIOD - 1`.
  - `inflight` increments.
- **STREAM.**
  - On acceptance, `idx` increments.
  - On acceptance with `idx == FRAME_LEN - 1`: `idx <= 0`, state goes to IDLE.
  - Gaps (`s_vld` low) are allowed; `p_vld` stays low for those cycles.
- **Period counter.** `per_cnt` decrements by 1 each cycle while nonzero and saturates at 0. A frame-start load overrides the decrement.
- **Forwarding.** `p_vld <= accept`, `p_data <= s_data`. `p_data` holds its previous value when `p_vld` is low.
- **Length check.** Evaluated on each accepted sample:
  - `s_last` high with `idx != FRAME_LEN - 1` sets `err[0]`.
  - `s_last` low with `idx == FRAME_LEN - 1` also sets `err[0]`.
  - Framing is driven by `idx` only; `s_last` never changes framing.
- **Result tagging.**
  - If `p_res_vld` and `inflight != 0`: `o_vld <= 1`, `o_tag <= res_id`, `res_id` increments (wraps modulo 2^TAG_W), `inflight` decrements.
  - If `p_res_vld` and `inflight == 0`: `err[1]` is set, `o_vld` stays low, `res_id` is unchanged.
  - Otherwise `o_vld <= 0`.
- **Simultaneous frame start and valid result.** `inflight` is unchanged. The spurious check uses the pre-cycle value of `inflight`.
- **Error bits.** Both bits clear only on `rst`.

## Timing
- Reset values:
  - state IDLE; `idx`, `per_cnt`, `inflight`, `res_id` = 0.
  - `p_vld` 0, `p_data` 0, `o_vld` 0, `o_tag` 0, `err` 0.
  - `s_rdy` is 1 in the cycle after `rst` deasserts.
- Latency:
  - Accepted sample to `p_vld`/`p_data`: 1 cycle.
  - `p_res_vld` to `o_vld`/`o_tag`: 1 cycle.
- Back-to-back frames: with `MIN_PERIOD ≤ FRAME_LEN` and credit available, the first sample of frame N+1 is accepted in the cycle after the last sample of frame N, with zero bubbles.
- With `MIN_PERIOD > FRAME_LEN`: `s_rdy` is low for exactly `MIN_PERIOD - FRAME_LEN` cycles between frames when upstream is continuously valid.
- Credit exhausted: `s_rdy` stays low in IDLE. It rises the cycle after the `p_res_vld` that frees a slot, provided `per_cnt == 0`.
- `rst` asserted mid-frame: the partial frame is abandoned. No `p_vld` is issued in the cycle after `rst`. Credit and tags restart from 0. The pipeline is reset by the same `rst`.

## Structure
- Shared package `tw_pkg`:
  - `typedef enum logic {IDLE, STREAM} sched_state_t`.
  - Error bit index constants `ERR_LEN = 0`, `ERR_SPUR = 1`.
  - Default `FRAME_LEN` / `MIN_PERIOD` constants matching `tw_vgg`'s input `LOG2_IMG_SIZE`.
- One sub-module, `sat_down_cntr`: a loadable saturating down-counter used for `per_cnt`.
- Everything else stays flat in `tw_frame_sched`.

## Test plan
All scenarios use `FRAME_LEN=8`, `MIN_PERIOD=12`, `MAX_INFLIGHT=2`, `TAG_W=4`.
- **Continuous source with correct `s_last`, results 40 cycles after each start.**
  - `s_rdy` pattern: 8 high, 4 low, repeating, until 2 frames are in flight.
  - `p_vld` mirrors acceptance 1 cycle later.
  - `o_tag` sequence is 0, 1, 2, …
- **Credit stall: no `p_res_vld` for 100 cycles.**
  - Exactly 16 samples are accepted; `inflight` = 2; `s_rdy` is held low.
  - One `p_res_vld` pulse: `s_rdy` is high the next cycle; `o_vld` = 1 with `o_tag` = 0.
- **Simultaneous frame start and `p_res_vld`.** `inflight` is unchanged that cycle; `err` = 0.
- **`p_res_vld` after reset with no frame sent.** `err` = 2'b10; `o_vld` stays 0; `res_id` stays 0.
- **`s_last` on sample index 5 of the first frame.** `err[0]` = 1; the frame still ends after index 7; the next frame starts normally.
- **`rst` pulse at sample index 3.**
  - The cycle after `rst` deasserts: all outputs 0, `s_rdy` = 1.
  - The next accepted sample is index 0; `inflight` goes 0 → 1.
